// File: rtl/pcie_mem_alloc_pkg.sv
// Shared constants for the PCIe memory-allocator register block.
package pcie_mem_alloc_pkg;

  // Byte offsets of the host-visible registers; decode uses offset[11:2].
  localparam logic [11:0] REG_ALLOC_PUSH = 12'h000;
  localparam logic [11:0] REG_FREE_POP   = 12'h004;
  localparam logic [11:0] REG_STATUS     = 12'h008;
  localparam logic [11:0] REG_DROP_CNT   = 12'h00C;

  // STATUS register field positions.
  localparam int STATUS_ALLOC_CNT_LSB     = 0;
  localparam int STATUS_DEALLOC_CNT_LSB   = 8;
  localparam int STATUS_ALLOC_FULL_BIT    = 16;
  localparam int STATUS_DEALLOC_EMPTY_BIT = 17;

  // AXI OKAY response; this block never signals an error.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Word index of a register byte offset, as seen by the address decoder.
  function automatic logic [9:0] reg_word(input logic [11:0] offset);
    return offset[11:2];
  endfunction

endpackage

// File: rtl/mem_alloc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module mem_alloc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_mem_alloc_regs.sv
// AXI4-Lite register block bridging host-supplied free chunk addresses to the
// memcached allocator (alloc FIFO) and returning freed addresses (dealloc FIFO).
module pcie_mem_alloc_regs
  import pcie_mem_alloc_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  axi_clk,
  input  logic                  axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           alloc_addr_data,
  output logic                  alloc_addr_valid,
  input  logic                  alloc_addr_ready,
  input  logic [31:0]           free_addr_data,
  input  logic                  free_addr_valid,
  output logic                  free_addr_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             aw_held;
  logic             w_held;
  logic [9:0]       aw_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             do_write;
  logic             wr_alloc;
  logic             alloc_accept;
  logic             wr_drop_clr;
  logic [31:0]      drop_cnt;
  logic             ar_hs;
  logic [9:0]       ar_idx;
  logic [31:0]      rd_value;
  logic [31:0]      status_word;
  logic             alloc_pop;
  logic             alloc_full;
  logic             alloc_empty;
  logic [CNT_W-1:0] alloc_count;
  logic             dealloc_push;
  logic             dealloc_pop;
  logic [31:0]      dealloc_head;
  logic             dealloc_full;
  logic             dealloc_empty;
  logic [CNT_W-1:0] dealloc_count;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_awaddr[1:0],
                              s_axi_araddr[ADDR_WIDTH-1:12], s_axi_araddr[1:0]};

  assign s_axi_awready = !aw_held;
  assign s_axi_wready  = !w_held;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;

  // A write fires once both beats are held and no response is outstanding.
  assign do_write     = aw_held && w_held && !s_axi_bvalid;
  assign wr_alloc     = do_write && (aw_idx == reg_word(REG_ALLOC_PUSH)) && (w_strb == 4'hF);
  assign alloc_accept = wr_alloc && (!alloc_full || alloc_pop);
  assign wr_drop_clr  = do_write && (aw_idx == reg_word(REG_DROP_CNT));

  assign alloc_addr_valid = !alloc_empty;
  assign alloc_pop        = alloc_addr_valid && alloc_addr_ready;

  assign free_addr_ready = !dealloc_full;
  assign dealloc_push    = free_addr_valid && free_addr_ready;

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign ar_idx      = s_axi_araddr[11:2];
  assign dealloc_pop = ar_hs && (ar_idx == reg_word(REG_FREE_POP)) && !dealloc_empty;

  mem_alloc_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_alloc_fifo (
    .clk       (axi_clk),
    .rst_n     (axi_aresetn),
    .push      (alloc_accept),
    .push_data (w_data),
    .pop       (alloc_pop),
    .head_data (alloc_addr_data),
    .count     (alloc_count),
    .full      (alloc_full),
    .empty     (alloc_empty)
  );

  mem_alloc_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_dealloc_fifo (
    .clk       (axi_clk),
    .rst_n     (axi_aresetn),
    .push      (dealloc_push),
    .push_data (free_addr_data),
    .pop       (dealloc_pop),
    .head_data (dealloc_head),
    .count     (dealloc_count),
    .full      (dealloc_full),
    .empty     (dealloc_empty)
  );

  // Read-data mux; STATUS is built from FIFO state before this cycle's push/pop.
  always_comb begin
    status_word = '0;
    status_word[STATUS_ALLOC_CNT_LSB +: 8]   = 8'(alloc_count);
    status_word[STATUS_DEALLOC_CNT_LSB +: 8] = 8'(dealloc_count);
    status_word[STATUS_ALLOC_FULL_BIT]       = alloc_full;
    status_word[STATUS_DEALLOC_EMPTY_BIT]    = dealloc_empty;
    rd_value = '0;
    if (ar_idx == reg_word(REG_FREE_POP)) begin
      rd_value = dealloc_empty ? 32'h0 : dealloc_head;
    end else if (ar_idx == reg_word(REG_STATUS)) begin
      rd_value = status_word;
    end else if (ar_idx == reg_word(REG_DROP_CNT)) begin
      rd_value = drop_cnt;
    end
  end

  // Write channel: latch AW and W independently, respond once, then re-open both.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
    end else if (s_axi_bvalid && s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
    end else begin
      if (s_axi_awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[11:2];
      end
      if (s_axi_wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (do_write) begin
        s_axi_bvalid <= 1'b1;
      end
    end
  end

  // Drop counter: cleared by any DROP_CNT write, saturating on rejected pushes.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      drop_cnt <= '0;
    end else if (wr_drop_clr) begin
      drop_cnt <= '0;
    end else if (wr_alloc && !alloc_accept && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Read channel: one read in flight, data registered at AR accept and held.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else if (ar_hs) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b1;
      s_axi_rdata   <= rd_value;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid  <= 1'b0;
      s_axi_arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_mem_alloc_regs.sv
// Directed testbench for pcie_mem_alloc_regs with hand-computed expectations.
module tb_pcie_mem_alloc_regs;

  logic        axi_clk;
  logic        axi_aresetn;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] alloc_addr_data;
  logic        alloc_addr_valid;
  logic        alloc_addr_ready;
  logic [31:0] free_addr_data;
  logic        free_addr_valid;
  logic        free_addr_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  pcie_mem_alloc_regs #(.FIFO_DEPTH(16), .ADDR_WIDTH(32)) dut (
    .axi_clk          (axi_clk),
    .axi_aresetn      (axi_aresetn),
    .s_axi_awaddr     (s_axi_awaddr),
    .s_axi_awvalid    (s_axi_awvalid),
    .s_axi_awready    (s_axi_awready),
    .s_axi_wdata      (s_axi_wdata),
    .s_axi_wstrb      (s_axi_wstrb),
    .s_axi_wvalid     (s_axi_wvalid),
    .s_axi_wready     (s_axi_wready),
    .s_axi_bresp      (s_axi_bresp),
    .s_axi_bvalid     (s_axi_bvalid),
    .s_axi_bready     (s_axi_bready),
    .s_axi_araddr     (s_axi_araddr),
    .s_axi_arvalid    (s_axi_arvalid),
    .s_axi_arready    (s_axi_arready),
    .s_axi_rdata      (s_axi_rdata),
    .s_axi_rresp      (s_axi_rresp),
    .s_axi_rvalid     (s_axi_rvalid),
    .s_axi_rready     (s_axi_rready),
    .alloc_addr_data  (alloc_addr_data),
    .alloc_addr_valid (alloc_addr_valid),
    .alloc_addr_ready (alloc_addr_ready),
    .free_addr_data   (free_addr_data),
    .free_addr_valid  (free_addr_valid),
    .free_addr_ready  (free_addr_ready)
  );

  // Free-running clock, 10 ns period.
  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Full AXI write: AW and W together, wait for B, return response and completion flag.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    bit aw_take;
    bit w_take;
    int n;
    ok = 1'b1;
    @(negedge axi_clk);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      aw_take = s_axi_awvalid && s_axi_awready;
      w_take  = s_axi_wvalid && s_axi_wready;
      @(negedge axi_clk);
      if (aw_take) s_axi_awvalid = 1'b0;
      if (w_take)  s_axi_wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge axi_clk);
      n++;
    end
    if (!s_axi_bvalid || s_axi_awvalid || s_axi_wvalid) ok = 1'b0;
    resp = s_axi_bresp;
    @(negedge axi_clk);
    s_axi_bready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  // Full AXI read: AR handshake, wait for R, return data, response and completion flag.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit take;
    int n;
    ok = 1'b1;
    @(negedge axi_clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (s_axi_arvalid && n < 20) begin
      take = s_axi_arready;
      @(negedge axi_clk);
      if (take) s_axi_arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge axi_clk);
      n++;
    end
    if (!s_axi_rvalid || s_axi_arvalid) ok = 1'b0;
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(negedge axi_clk);
    s_axi_rready = 1'b0; s_axi_arvalid = 1'b0;
  endtask

  // One-cycle ready pulse toward the alloc stream.
  task automatic alloc_pulse();
    @(negedge axi_clk);
    alloc_addr_ready = 1'b1;
    @(negedge axi_clk);
    alloc_addr_ready = 1'b0;
  endtask

  // Reset values, both while held in reset and after release.
  task automatic test_reset();
    axi_aresetn = 1'b0;
    repeat (3) @(negedge axi_clk);
    total_cnt++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
         alloc_addr_valid, free_addr_ready} !== 7'b1110001) begin
      $display("[TB] FAIL reset_handshake: got %b expected 1110001",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                alloc_addr_valid, free_addr_ready});
    end else pass_cnt++;
    total_cnt++;
    if ({s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 36'h0) begin
      $display("[TB] FAIL reset_data: rdata %h bresp %b rresp %b expected all zero",
               s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end else pass_cnt++;
    axi_aresetn = 1'b1;
    repeat (2) @(negedge axi_clk);
    total_cnt++;
    if ({s_axi_awready, s_axi_arready, s_axi_bvalid, alloc_addr_valid, free_addr_ready} !== 5'b11001) begin
      $display("[TB] FAIL reset_release: got %b expected 11001",
               {s_axi_awready, s_axi_arready, s_axi_bvalid, alloc_addr_valid, free_addr_ready});
    end else pass_cnt++;
  endtask

  // Two pushes, drained one beat at a time, STATUS count tracking 2->1->0.
  task automatic test_alloc_push();
    logic [1:0] resp; logic [31:0] rd; bit ok;
    axi_write(32'h000, 32'h1000, 4'hF, resp, ok);
    total_cnt++;
    if (!ok || resp !== 2'b00) $display("[TB] FAIL push1_bresp: ok %0d resp %b expected 1/00", ok, resp);
    else pass_cnt++;
    axi_write(32'h000, 32'h2000, 4'hF, resp, ok);
    total_cnt++;
    if ({alloc_addr_valid, alloc_addr_data} !== {1'b1, 32'h1000})
      $display("[TB] FAIL alloc_head0: valid %b data %h expected 1/00001000", alloc_addr_valid, alloc_addr_data);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0002) $display("[TB] FAIL status_cnt2: got %h expected 00020002", rd);
    else pass_cnt++;
    alloc_pulse();
    total_cnt++;
    if ({alloc_addr_valid, alloc_addr_data} !== {1'b1, 32'h2000})
      $display("[TB] FAIL alloc_head1: valid %b data %h expected 1/00002000", alloc_addr_valid, alloc_addr_data);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0001) $display("[TB] FAIL status_cnt1: got %h expected 00020001", rd);
    else pass_cnt++;
    alloc_pulse();
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0000 || alloc_addr_valid !== 1'b0)
      $display("[TB] FAIL status_cnt0: got %h valid %b expected 00020000/0", rd, alloc_addr_valid);
    else pass_cnt++;
  endtask

  // Seventeen pushes into a 16-deep FIFO: full flag, one drop, DROP_CNT clear, order on drain.
  task automatic test_overflow();
    logic [1:0] resp; logic [31:0] rd; bit ok;
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h000, 32'h100 + 32'(i * 4), 4'hF, resp, ok);
    end
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0003_0010) $display("[TB] FAIL status_full: got %h expected 00030010", rd);
    else pass_cnt++;
    axi_read(32'h00C, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h1) $display("[TB] FAIL drop_cnt_one: got %h expected 00000001", rd);
    else pass_cnt++;
    axi_write(32'h00C, 32'h1234, 4'hF, resp, ok);
    axi_read(32'h00C, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0) $display("[TB] FAIL drop_cnt_clear: got %h expected 00000000", rd);
    else pass_cnt++;
    total_cnt++;
    if (alloc_addr_data !== 32'h100) $display("[TB] FAIL overflow_head: got %h expected 00000100", alloc_addr_data);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) alloc_pulse();
    total_cnt++;
    if ({alloc_addr_valid, alloc_addr_data} !== {1'b1, 32'h13C})
      $display("[TB] FAIL overflow_tail: valid %b data %h expected 1/0000013c", alloc_addr_valid, alloc_addr_data);
    else pass_cnt++;
    alloc_pulse();
    total_cnt++;
    if (alloc_addr_valid !== 1'b0) $display("[TB] FAIL overflow_drained: valid %b expected 0", alloc_addr_valid);
    else pass_cnt++;
  endtask

  // Two freed addresses pushed on the stream, then popped by three FREE_POP reads.
  task automatic test_free_pop();
    logic [1:0] resp; logic [31:0] rd; bit ok;
    @(negedge axi_clk);
    free_addr_data = 32'hA0; free_addr_valid = 1'b1;
    @(negedge axi_clk);
    free_addr_data = 32'hA4;
    @(negedge axi_clk);
    free_addr_valid = 1'b0;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0000_0200) $display("[TB] FAIL status_dealloc2: got %h expected 00000200", rd);
    else pass_cnt++;
    axi_read(32'h004, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'hA0) $display("[TB] FAIL free_pop0: got %h expected 000000a0", rd);
    else pass_cnt++;
    axi_read(32'h004, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'hA4) $display("[TB] FAIL free_pop1: got %h expected 000000a4", rd);
    else pass_cnt++;
    axi_read(32'h004, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0) $display("[TB] FAIL free_pop_empty: got %h expected 00000000", rd);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0000) $display("[TB] FAIL status_dealloc_empty: got %h expected 00020000", rd);
    else pass_cnt++;
  endtask

  // AW three cycles ahead of W, bready held low five cycles after bvalid.
  task automatic test_aw_before_w();
    logic [1:0] resp; logic [31:0] rd; bit ok; bit hold_ok; int n;
    @(negedge axi_clk);
    s_axi_awaddr = 32'h000; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
    @(negedge axi_clk);
    s_axi_awvalid = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (s_axi_awready !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_wready !== 1'b1) hold_ok = 1'b0;
      @(negedge axi_clk);
    end
    total_cnt++;
    if (!hold_ok) $display("[TB] FAIL aw_only_wait: awready %b bvalid %b wready %b expected 0/0/1",
                           s_axi_awready, s_axi_bvalid, s_axi_wready);
    else pass_cnt++;
    s_axi_wdata = 32'h3000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge axi_clk);
    s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge axi_clk);
      n++;
    end
    hold_ok = s_axi_bvalid;
    for (int i = 0; i < 5; i++) begin
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) hold_ok = 1'b0;
      @(negedge axi_clk);
    end
    total_cnt++;
    if (!hold_ok) $display("[TB] FAIL bvalid_hold: bvalid %b awready %b wready %b expected 1/0/0",
                           s_axi_bvalid, s_axi_awready, s_axi_wready);
    else pass_cnt++;
    s_axi_bready = 1'b1;
    @(negedge axi_clk);
    s_axi_bready = 1'b0;
    total_cnt++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011)
      $display("[TB] FAIL b_release: got %b expected 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0001 || alloc_addr_data !== 32'h3000)
      $display("[TB] FAIL single_push: status %h head %h expected 00020001/00003000", rd, alloc_addr_data);
    else pass_cnt++;
    alloc_pulse();
  endtask

  // Partial-strobe push is ignored but acknowledged; unmapped read returns zero OKAY.
  task automatic test_partial_strobe();
    logic [1:0] resp; logic [31:0] rd; bit ok;
    axi_write(32'h000, 32'hDEAD, 4'h3, resp, ok);
    total_cnt++;
    if (!ok || resp !== 2'b00) $display("[TB] FAIL partial_bresp: ok %0d resp %b expected 1/00", ok, resp);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0000 || alloc_addr_valid !== 1'b0)
      $display("[TB] FAIL partial_ignored: status %h valid %b expected 00020000/0", rd, alloc_addr_valid);
    else pass_cnt++;
    axi_read(32'h040, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0 || resp !== 2'b00)
      $display("[TB] FAIL unmapped_read: data %h resp %b expected 00000000/00", rd, resp);
    else pass_cnt++;
  endtask

  // Dealloc FIFO full with a waiting producer while FREE_POP is accepted.
  task automatic test_full_pop_push();
    logic [1:0] resp; logic [31:0] rd; bit ok; logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge axi_clk);
      free_addr_data = 32'hB00 + 32'(i * 4); free_addr_valid = 1'b1;
    end
    @(negedge axi_clk);
    free_addr_data = 32'hC00;
    total_cnt++;
    if (free_addr_ready !== 1'b0) $display("[TB] FAIL dealloc_full_ready: got %b expected 0", free_addr_ready);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0000_1000) $display("[TB] FAIL status_dealloc_full: got %h expected 00001000", rd);
    else pass_cnt++;
    axi_read(32'h004, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'hB00) $display("[TB] FAIL full_pop_head: got %h expected 00000b00", rd);
    else pass_cnt++;
    repeat (2) @(negedge axi_clk);
    total_cnt++;
    if (free_addr_ready !== 1'b0) $display("[TB] FAIL refill_ready: got %b expected 0", free_addr_ready);
    else pass_cnt++;
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0000_1000) $display("[TB] FAIL status_refill: got %h expected 00001000", rd);
    else pass_cnt++;
    free_addr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'hB04 + 32'(i * 4) : 32'hC00;
      axi_read(32'h004, rd, resp, ok);
      total_cnt++;
      if (!ok || rd !== exp) $display("[TB] FAIL drain_%0d: got %h expected %h", i, rd, exp);
      else pass_cnt++;
    end
    axi_read(32'h008, rd, resp, ok);
    total_cnt++;
    if (!ok || rd !== 32'h0002_0000) $display("[TB] FAIL status_after_drain: got %h expected 00020000", rd);
    else pass_cnt++;
  endtask

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    axi_aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    alloc_addr_ready = 1'b0;
    free_addr_data = '0; free_addr_valid = 1'b0;
    test_reset();
    test_alloc_push();
    test_overflow();
    test_free_pop();
    test_aw_before_w();
    test_partial_strobe();
    test_full_pop_push();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
